// File: rtl/kp_voice_alloc.sv
// rtl/kp_voice_alloc.sv - voice allocator/scheduler for a bank of Karplus-Strong pluck voices
// Free voice first, else oldest voice; parameters load one cycle before the trigger rises.
module kp_voice_alloc #(
  parameter int          NUM_VOICES   = 4,
  parameter int          VIDX_W       = 2,
  parameter logic [10:0] MIN_LEN      = 11'd16,
  parameter int          TRIG_HOLD    = 8,
  parameter int          TRIG_GAP     = 8,
  parameter int          DECAY_CYCLES = 48000
) (
  input  logic                       a_clk,
  input  logic                       reset_n,
  input  logic                       i_note_valid,
  output logic                       o_note_ready,
  input  logic [10:0]                i_note_len,
  input  logic [2:0]                 i_note_filt,
  output logic [NUM_VOICES*11-1:0]   o_voice_len,
  output logic [NUM_VOICES*3-1:0]    o_voice_filt,
  output logic [NUM_VOICES-1:0]      o_voice_trig,
  output logic [NUM_VOICES-1:0]      o_voice_busy,
  output logic [VIDX_W-1:0]          o_last_voice,
  output logic                       o_steal
);

  localparam int AGE_W   = $clog2(DECAY_CYCLES + 1);
  localparam int CNT_MAX = (TRIG_HOLD > TRIG_GAP) ? TRIG_HOLD : TRIG_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(DECAY_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_LOAD, S_TRIG, S_GAP
  } state_t;

  state_t                  r_state;
  logic                    r_note_ready;
  logic [10:0]             r_len_q;
  logic [2:0]              r_filt_q;
  logic [VIDX_W-1:0]       r_target;
  logic [VIDX_W-1:0]       r_last_voice;
  logic                    r_steal;
  logic [NUM_VOICES-1:0]   r_trig;
  logic [CNT_W-1:0]        r_cnt;
  logic [10:0]             r_voice_len  [NUM_VOICES];
  logic [2:0]              r_voice_filt [NUM_VOICES];
  logic [AGE_W-1:0]        r_age        [NUM_VOICES];

  logic [NUM_VOICES-1:0]   w_busy;
  logic                    w_free_found;
  logic [VIDX_W-1:0]       w_free_idx;
  logic [VIDX_W-1:0]       w_old_idx;
  logic [AGE_W-1:0]        w_old_age;

  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    w_busy       = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_old_idx    = '0;
    w_old_age    = r_age[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_busy[i] = (r_age[i] < AGE_SAT);
      if (!w_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = VIDX_W'(i);
      end
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = VIDX_W'(i);
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_note_ready <= 1'b0;
      r_len_q      <= '0;
      r_filt_q     <= '0;
      r_target     <= '0;
      r_last_voice <= '0;
      r_steal      <= 1'b0;
      r_trig       <= '0;
      r_cnt        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_voice_len[i]  <= MIN_LEN;
        r_voice_filt[i] <= '0;
        r_age[i]        <= AGE_SAT;
      end
    end else begin
      r_steal <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (r_age[i] != AGE_SAT) r_age[i] <= r_age[i] + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_note_ready && i_note_valid) begin
            r_len_q      <= i_note_len;
            r_filt_q     <= i_note_filt;
            r_note_ready <= 1'b0;
            r_state      <= S_SEL;
          end else begin
            r_note_ready <= 1'b1;
          end
        end
        S_SEL: begin
          if (w_free_found) begin
            r_target <= w_free_idx;
          end else begin
            r_target <= w_old_idx;
            r_steal  <= 1'b1;
          end
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // Age clear is written after the increment loop so it takes priority.
          r_voice_len[r_target]  <= (r_len_q < MIN_LEN) ? MIN_LEN : r_len_q;
          r_voice_filt[r_target] <= r_filt_q;
          r_age[r_target]        <= '0;
          r_last_voice           <= r_target;
          r_cnt                  <= '0;
          r_state                <= S_TRIG;
        end
        S_TRIG: begin
          if (r_cnt == CNT_W'(TRIG_HOLD)) begin
            r_trig  <= '0;
            r_cnt   <= CNT_W'(1);
            r_state <= S_GAP;
          end else begin
            r_trig <= NUM_VOICES'(1) << r_target;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(TRIG_GAP)) begin
            r_note_ready <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign o_voice_len[11*g +: 11] = r_voice_len[g];
    assign o_voice_filt[3*g +: 3]  = r_voice_filt[g];
  end

  assign o_note_ready = r_note_ready;
  assign o_voice_trig = r_trig;
  assign o_voice_busy = w_busy;
  assign o_last_voice = r_last_voice;
  assign o_steal      = r_steal;

endmodule

// File: tb/tb_kp_voice_alloc.sv
// tb/tb_kp_voice_alloc.sv - directed self-checking bench for kp_voice_alloc
module tb_kp_voice_alloc;

  logic        a_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        note_valid = 1'b0;
  logic [10:0] note_len = '0;
  logic [2:0]  note_filt = '0;
  logic        o_note_ready;
  logic [43:0] o_voice_len;
  logic [11:0] o_voice_filt;
  logic [3:0]  o_voice_trig;
  logic [3:0]  o_voice_busy;
  logic [1:0]  o_last_voice;
  logic        o_steal;

  int errs   = 0;
  int checks = 0;
  logic [10:0] m_len  [4];
  logic [2:0]  m_filt [4];

  kp_voice_alloc dut (
    .a_clk        (a_clk),
    .reset_n      (reset_n),
    .i_note_valid (note_valid),
    .o_note_ready (o_note_ready),
    .i_note_len   (note_len),
    .i_note_filt  (note_filt),
    .o_voice_len  (o_voice_len),
    .o_voice_filt (o_voice_filt),
    .o_voice_trig (o_voice_trig),
    .o_voice_busy (o_voice_busy),
    .o_last_voice (o_last_voice),
    .o_steal      (o_steal)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int v = 0; v < 4; v++) begin
      chk({tag, "_len"}, 32'(o_voice_len[11*v +: 11]), 32'(m_len[v]));
      chk({tag, "_filt"}, 32'(o_voice_filt[3*v +: 3]), 32'(m_filt[v]));
    end
  endtask

  // Asserts reset across two edges, checks reset state and first ready after release.
  task automatic do_reset();
    reset_n = 1'b0;
    note_valid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      m_len[v]  = 11'd16;
      m_filt[v] = 3'd0;
    end
    repeat (2) @(negedge a_clk);
    chk("rst_ready", 32'(o_note_ready), 32'd0);
    chk("rst_trig", 32'(o_voice_trig), 32'd0);
    chk("rst_busy", 32'(o_voice_busy), 32'd0);
    chk("rst_steal", 32'(o_steal), 32'd0);
    chk("rst_last", 32'(o_last_voice), 32'd0);
    check_regs("rst");
    reset_n = 1'b1;
    @(negedge a_clk);
    chk("rst_ready_rel", 32'(o_note_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after edge T+19.
  task automatic send(input logic [10:0] len, input logic [2:0] filt,
                      input int exp_v, input logic exp_steal, input logic hold);
    int n;
    logic [10:0] cl;
    cl = (len < 11'd16) ? 11'd16 : len;
    note_valid = 1'b1;
    note_len   = len;
    note_filt  = filt;
    n = 0;
    while (!o_note_ready && n < 100) begin
      @(negedge a_clk);
      n++;
    end
    chk("ready_wait", 32'(o_note_ready), 32'd1);
    @(negedge a_clk);
    if (!hold) note_valid = 1'b0;
    chk("ready_drop", 32'(o_note_ready), 32'd0);
    @(negedge a_clk);
    chk("steal", 32'(o_steal), 32'(exp_steal));
    @(negedge a_clk);
    m_len[exp_v]  = cl;
    m_filt[exp_v] = filt;
    check_regs("load");
    chk("last_voice", 32'(o_last_voice), 32'(exp_v));
    chk("busy_set", 32'(o_voice_busy[exp_v]), 32'd1);
    chk("trig_pre", 32'(o_voice_trig), 32'd0);
    chk("steal_once", 32'(o_steal), 32'd0);
    @(negedge a_clk);
    chk("trig_rise", 32'(o_voice_trig), 32'(4'b1 << exp_v));
    repeat (7) @(negedge a_clk);
    chk("trig_hold", 32'(o_voice_trig), 32'(4'b1 << exp_v));
    @(negedge a_clk);
    chk("trig_fall", 32'(o_voice_trig), 32'd0);
    repeat (7) @(negedge a_clk);
    chk("gap_ready", 32'(o_note_ready), 32'd0);
    @(negedge a_clk);
    chk("ready_back", 32'(o_note_ready), 32'd1);
    check_regs("post");
  endtask

  initial begin
    int n;
    @(negedge a_clk);
    do_reset();

    // single pluck to voice0
    send(11'd200, 3'd3, 0, 1'b0, 1'b0);

    // four back-to-back with valid held, then steal the oldest
    do_reset();
    send(11'd100, 3'd1, 0, 1'b0, 1'b1);
    send(11'd110, 3'd2, 1, 1'b0, 1'b1);
    send(11'd120, 3'd4, 2, 1'b0, 1'b1);
    send(11'd130, 3'd5, 3, 1'b0, 1'b0);
    chk("busy_all", 32'(o_voice_busy), 32'hf);
    send(11'd500, 3'd6, 0, 1'b1, 1'b0);

    // clamp and max length, both stealing the oldest remaining voice
    send(11'd5, 3'd7, 1, 1'b1, 1'b0);
    send(11'd2047, 3'd0, 2, 1'b1, 1'b0);

    // decay: load at edge L, returned at L+17; busy clears at L+48000
    do_reset();
    send(11'd300, 3'd2, 0, 1'b0, 1'b0);
    repeat (47982) @(negedge a_clk);
    chk("decay_busy_hi", 32'(o_voice_busy), 32'h1);
    @(negedge a_clk);
    chk("decay_busy_lo", 32'(o_voice_busy), 32'h0);
    send(11'd400, 3'd1, 0, 1'b0, 1'b0);

    // reset during TRIG
    do_reset();
    note_valid = 1'b1;
    note_len   = 11'd700;
    note_filt  = 3'd5;
    n = 0;
    while (!o_note_ready && n < 100) begin
      @(negedge a_clk);
      n++;
    end
    chk("r6_ready", 32'(o_note_ready), 32'd1);
    @(negedge a_clk);
    note_valid = 1'b0;
    repeat (4) @(negedge a_clk);
    chk("r6_trig_on", 32'(o_voice_trig), 32'h1);
    reset_n = 1'b0;
    @(negedge a_clk);
    chk("r6_trig_off", 32'(o_voice_trig), 32'd0);
    chk("r6_ready_off", 32'(o_note_ready), 32'd0);
    chk("r6_busy", 32'(o_voice_busy), 32'd0);
    check_regs("r6");
    reset_n = 1'b1;
    @(negedge a_clk);
    chk("r6_ready_rel", 32'(o_note_ready), 32'd1);
    send(11'd900, 3'd4, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
